// File: rtl/timer_ctrl.sv
// Two-digit BCD up-counter with prescaled tick, start/stop/clear control and target match.
// IDLE/RUN/PAUSE/DONE sequencing; every output is taken straight from a register.
module timer_ctrl #(
    parameter int unsigned TICK_DIV = 10
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic [7:0] target,
    output logic [3:0] ones,
    output logic [3:0] tens,
    output logic [1:0] state,
    output logic       running,
    output logic       done,
    output logic       err
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_t;

    localparam logic [15:0] PRESC_MAX = 16'(TICK_DIV - 1);

    state_t      state_q, state_d;
    logic [3:0]  ones_q, ones_d, tens_q, tens_d;
    logic [15:0] presc_q, presc_d;
    logic [7:0]  tgt_q, tgt_d;
    logic        running_q, running_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic        tgt_ok;
    logic [3:0]  ones_inc, tens_inc;

    assign tgt_ok   = (target[7:4] <= 4'd9) && (target[3:0] <= 4'd9);
    assign ones_inc = (ones_q == 4'd9) ? 4'd0 : ones_q + 4'd1;
    assign tens_inc = (ones_q != 4'd9) ? tens_q :
                      (tens_q == 4'd9) ? 4'd0 : tens_q + 4'd1;

    always_comb begin
        state_d = state_q;
        ones_d  = ones_q;
        tens_d  = tens_q;
        presc_d = presc_q;
        tgt_d   = tgt_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        if (clear) begin
            state_d = IDLE;
            ones_d  = 4'd0;
            tens_d  = 4'd0;
            presc_d = 16'd0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    // A rejected start leaves state, count and latched target untouched.
                    if (start) begin
                        if (tgt_ok) begin
                            state_d = RUN;
                            ones_d  = 4'd0;
                            tens_d  = 4'd0;
                            presc_d = 16'd0;
                            tgt_d   = target;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (stop) begin
                        state_d = PAUSE;
                    end else if (presc_q == PRESC_MAX) begin
                        presc_d = 16'd0;
                        ones_d  = ones_inc;
                        tens_d  = tens_inc;
                        if ({tens_inc, ones_inc} == tgt_q) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        presc_d = presc_q + 16'd1;
                    end
                end
                PAUSE: begin
                    if (start && !stop) state_d = RUN;
                end
                default: state_d = IDLE;
            endcase
        end
        running_d = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            ones_q    <= 4'd0;
            tens_q    <= 4'd0;
            presc_q   <= 16'd0;
            tgt_q     <= 8'h00;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ones_q    <= ones_d;
            tens_q    <= tens_d;
            presc_q   <= presc_d;
            tgt_q     <= tgt_d;
            running_q <= running_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign state   = state_q;
    assign ones    = ones_q;
    assign tens    = tens_q;
    assign running = running_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: doc/timer_ctrl.md
TIMER_CTRL -- requirements
Module: timer_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 10, clock cycles per count step in RUN; legal range 1..65535.
REQ-002 clk  input  1  system clock, all state changes on posedge.
REQ-003 rstn  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  level, sampled each posedge: begin, resume or restart counting.
REQ-005 stop  input  1  level, sampled each posedge: pause counting.
REQ-006 clear  input  1  level, sampled each posedge: abort to IDLE, zero the count.
REQ-007 target  input  8  BCD target, [7:4] tens digit, [3:0] ones digit; latched only when accepted by a start from IDLE or DONE.
REQ-008 ones  output  4  BCD ones digit of the current count, 0..9.
REQ-009 tens  output  4  BCD tens digit of the current count, 0..9.
REQ-010 state  output  2  00 IDLE, 01 RUN, 10 PAUSE, 11 DONE.
REQ-011 running  output  1  high exactly when state is RUN.
REQ-012 done  output  1  one-cycle pulse in the first cycle that state is DONE.
REQ-013 err  output  1  one-cycle pulse in the cycle after a start is rejected for invalid target.

Function
REQ-014 All outputs are registered; input effects are visible one cycle after the sampling edge.
REQ-015 clear, when high, takes priority in every state: next state IDLE, count 00, prescaler 0, no done or err pulse.
REQ-016 IDLE: start with valid target -> RUN, count 00, prescaler 0, target latched; stop alone has no effect.
REQ-017 A target is invalid when either digit exceeds 9; start in IDLE or DONE with an invalid target -> state unchanged, target register unchanged, err pulse.
REQ-018 RUN: prescaler counts 0..TICK_DIV-1 and wraps; a tick occurs on the edge where the prescaler equals TICK_DIV-1.
REQ-019 On a tick, ones increments modulo 10; when ones is 9, ones becomes 0 and tens increments modulo 10; a tick at 99 gives 00.
REQ-020 With TICK_DIV=1, a tick occurs on every RUN cycle.
REQ-021 RUN: after a tick, if the new count equals the latched target -> DONE with done pulse; target 00 therefore completes after 100 ticks.
REQ-022 RUN: stop high (start ignored) -> PAUSE; prescaler and count hold their values, with no tick on that edge.
REQ-023 PAUSE: start high with stop low -> RUN, resuming from the held prescaler and count; target is not re-latched or re-checked.
REQ-024 PAUSE: stop, or start and stop together -> remain in PAUSE.
REQ-025 DONE: count holds at target and done stays low after its pulse; start -> restart exactly as from IDLE (REQ-016, REQ-017); stop has no effect.
REQ-026 The target input is ignored outside an accepted or rejected start; changes while in RUN, PAUSE or DONE have no effect.

Reset
REQ-027 rstn low asynchronously forces state IDLE, count 00, prescaler 0, latched target 00, and running, done and err all 0.
REQ-028 Release of rstn is synchronised to clk by the integrator; the block acts on inputs from the first posedge after release.
REQ-029 rstn asserted in any state, including mid-tick in RUN, discards all progress; no done pulse is produced.

Verification
REQ-030 TICK_DIV=2, target 0x05, start pulse: running high for 10 cycles, count steps 01..05 every 2 cycles, state 11 and a single done pulse after the tick to 05.
REQ-031 TICK_DIV=3, target 0x20, run to count 07 then stop for 5 cycles then start: count frozen at 07 during the pause, and the next tick arrives after the remaining prescaler cycles (no lost or extra cycles).
REQ-032 TICK_DIV=1, target 0x00: count passes 09->10 and 99->00, and done pulses after exactly 100 RUN cycles.
REQ-033 start with target 0x3A in IDLE: err pulses once, state stays 00; same target on a start in DONE: err pulses, count and state unchanged.
REQ-034 clear together with start and stop while in RUN: state 00 and count 00 on the next cycle, with no done pulse.
REQ-035 rstn low mid-RUN between clock edges: all outputs go to reset values immediately, without waiting for clk.
